// File: rtl/conv_asd_pkg.sv
// Shared types and constants for the CSD digit scanner: FSM states, the
// controller strobe bundle and the state-to-strobe decode.
package conv_asd_pkg;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int KW    = 4;
  localparam int CW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_READ,
    ST_CHECK,
    ST_SAVE,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic load;
    logic re_csd;
    logic enable;
    logic en_cnt;
    logic load_cnt;
    logic re_k;
    logic we_k;
    logic k_sel;
    logic sel_save_k;
    logic done;
  } strobes_t;

  // Moore decode: every strobe is a pure function of the state it belongs to.
  function automatic strobes_t decode_state(input state_t s);
    strobes_t st;
    st = '0;
    case (s)
      ST_INIT: begin
        st.load     = 1'b1;
        st.load_cnt = 1'b1;
      end
      ST_READ: st.re_csd = 1'b1;
      ST_SAVE: begin
        st.we_k       = 1'b1;
        st.sel_save_k = 1'b1;
        st.en_cnt     = 1'b1;
      end
      ST_NEXT: st.enable = 1'b1;
      ST_DONE: begin
        st.done  = 1'b1;
        st.re_k  = 1'b1;
        st.k_sel = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/conv_asd_ctrl.sv
// Scan controller: walks every digit once, detours through SAVE for nonzero
// digits, and waits in DONE until start is released.
module conv_asd_ctrl
  import conv_asd_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  logic     zi,
  input  logic     zcsd,
  output state_t   state,
  output strobes_t strobes
);

  function automatic state_t next_state(input state_t s, input logic go,
                                        input logic last, input logic zero);
    state_t n;
    n = s;
    case (s)
      ST_IDLE:  n = go ? ST_INIT : ST_IDLE;
      ST_INIT:  n = ST_READ;
      ST_READ:  n = ST_CHECK;
      ST_CHECK: n = zero ? ST_NEXT : ST_SAVE;
      ST_SAVE:  n = ST_NEXT;
      ST_NEXT:  n = last ? ST_DONE : ST_READ;
      ST_DONE:  n = go ? ST_DONE : ST_IDLE;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Strobes are registered alongside the state so they always match it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      strobes <= '0;
    end else begin
      state   <= next_state(state, start, zi, zcsd);
      strobes <= decode_state(next_state(state, start, zi, zcsd));
    end
  end

endmodule

// File: rtl/conv_asd.sv
// CSD digit scanner: records the indices of nonzero digits of a 16-entry
// digit memory into the K memory in ascending order.
module conv_asd
  import conv_asd_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          weCsd,
  input  logic [KW-1:0] address,
  input  logic [DW-1:0] dataIn,
  input  logic          Zk,
  input  logic          ZCsdK,
  output logic [DW-1:0] dataOut,
  output logic [KW-1:0] dataOutK,
  output logic          Zi,
  output logic          Zcsd,
  output logic          Zcnt,
  output logic          done,
  output logic          Load,
  output logic          reCsd,
  output logic          enable,
  output logic          enCnt,
  output logic          loadCnt,
  output logic          reK,
  output logic          weK,
  output logic          kSel,
  output logic          selSaveK,
  output logic [KW-1:0] sel_i
);

  state_t        state;
  strobes_t      strobes;
  logic [DW-1:0] digit_mem [DEPTH];
  logic [KW-1:0] k_mem     [DEPTH];
  logic [KW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] data_reg;
  logic [KW-1:0] k_wdata;
  logic          host_write;
  logic          unused_status;

  // Reserved status inputs are accepted but intentionally ignored.
  assign unused_status = ^{Zk, ZCsdK};

  conv_asd_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .zi      (Zi),
    .zcsd    (Zcsd),
    .state   (state),
    .strobes (strobes)
  );

  assign host_write = weCsd && ((state == ST_IDLE) || (state == ST_DONE));
  assign k_wdata    = strobes.sel_save_k ? idx : address;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      cnt      <= '0;
      data_reg <= '0;
    end else begin
      if (strobes.load)
        idx <= '0;
      else if (strobes.enable)
        idx <= idx + 1'b1;

      if (strobes.load_cnt)
        cnt <= '0;
      else if (strobes.en_cnt)
        cnt <= cnt + 1'b1;

      if (strobes.re_csd)
        data_reg <= digit_mem[idx];
    end
  end

  // Both memories are cleared by reset so a fresh scan never sees stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        digit_mem[a] <= '0;
        k_mem[a]     <= '0;
      end
    end else begin
      if (host_write)
        digit_mem[address] <= dataIn;
      if (strobes.we_k)
        k_mem[cnt[KW-1:0]] <= k_wdata;
    end
  end

  assign dataOutK = strobes.k_sel ? k_mem[address] : k_mem[cnt[KW-1:0]];
  assign dataOut  = data_reg;
  assign sel_i    = idx;
  assign Zi       = (idx == KW'(DEPTH - 1));
  assign Zcsd     = (data_reg == '0);
  assign Zcnt     = (cnt == '0);

  assign done     = strobes.done;
  assign Load     = strobes.load;
  assign reCsd    = strobes.re_csd;
  assign enable   = strobes.enable;
  assign enCnt    = strobes.en_cnt;
  assign loadCnt  = strobes.load_cnt;
  assign reK      = strobes.re_k;
  assign weK      = strobes.we_k;
  assign kSel     = strobes.k_sel;
  assign selSaveK = strobes.sel_save_k;

endmodule

// File: tb/tb_conv_asd.sv
// Self-checking bench for conv_asd: table-driven scans, randomized scans
// against a list-based reference model, and abort/lockout/retrigger cases.
module tb_conv_asd;

  logic       clk;
  logic       reset;
  logic       start;
  logic       weCsd;
  logic [3:0] address;
  logic [7:0] dataIn;
  logic       Zk;
  logic       ZCsdK;
  logic [7:0] dataOut;
  logic [3:0] dataOutK;
  logic       Zi, Zcsd, Zcnt, done;
  logic       Load, reCsd, enable, enCnt, loadCnt, reK, weK, kSel, selSaveK;
  logic [3:0] sel_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [16];

  typedef struct {
    logic [15:0] mask;
    logic [7:0]  val;
    int          exp_cnt;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  conv_asd dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .weCsd    (weCsd),
    .address  (address),
    .dataIn   (dataIn),
    .Zk       (Zk),
    .ZCsdK    (ZCsdK),
    .dataOut  (dataOut),
    .dataOutK (dataOutK),
    .Zi       (Zi),
    .Zcsd     (Zcsd),
    .Zcnt     (Zcnt),
    .done     (done),
    .Load     (Load),
    .reCsd    (reCsd),
    .enable   (enable),
    .enCnt    (enCnt),
    .loadCnt  (loadCnt),
    .reK      (reK),
    .weK      (weK),
    .kSel     (kSel),
    .selSaveK (selSaveK),
    .sel_i    (sel_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the answer is simply the list of nonzero positions.
  function automatic int model_count();
    int n = 0;
    for (int a = 0; a < 16; a++)
      if (ref_mem[a] != 8'h00) n++;
    return n;
  endfunction

  task automatic apply_stimulus();
    for (int a = 0; a < 16; a++) begin
      weCsd   = 1'b1;
      address = 4'(a);
      dataIn  = ref_mem[a];
      tick();
    end
    weCsd   = 1'b0;
    address = 4'd0;
  endtask

  task automatic run_scan(input string tag, input int exp_lat,
                          input int exp_cnt, input int poke_at);
    int lat, wek, loads;
    int exp_k[$];
    exp_k = {};
    for (int a = 0; a < 16; a++)
      if (ref_mem[a] != 8'h00) exp_k.push_back(a);
    lat = 0; wek = 0; loads = 0;
    start = 1'b1;
    while (lat < 200) begin
      tick();
      lat++;
      weCsd = 1'b0;
      if (lat == poke_at) begin
        weCsd   = 1'b1;
        address = 4'd3;
        dataIn  = (ref_mem[3] == 8'h00) ? 8'h5A : 8'h00;
      end
      if (weK) wek++;
      if (Load) loads++;
      if (done) break;
    end
    weCsd = 1'b0;
    check_output({tag, " latency"}, lat, exp_lat);
    check_output({tag, " weK count"}, wek, exp_cnt);
    check_output({tag, " Load pulses"}, loads, 1);
    check_output({tag, " Zcnt"}, Zcnt, (exp_cnt == 0));
    check_output({tag, " dataOut"}, dataOut, ref_mem[15]);
    check_output({tag, " Zcsd"}, Zcsd, (ref_mem[15] == 8'h00));
    check_output({tag, " sel_i"}, sel_i, 0);
    check_output({tag, " kSel"}, kSel, 1);
    for (int j = 0; j < exp_k.size(); j++) begin
      address = 4'(j);
      #1;
      check_output({tag, " K entry"}, dataOutK, exp_k[j]);
    end
    repeat (3) tick();
    check_output({tag, " hold done"}, done, 1);
    check_output({tag, " hold Load"}, Load, 0);
    start = 1'b0;
    tick();
    check_output({tag, " release done"}, done, 0);
    check_output({tag, " release kSel"}, kSel, 0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{16'h8221, 8'h01, 4, 54};
    vecs[1] = '{16'h0000, 8'h01, 0, 50};
    vecs[2] = '{16'hFFFF, 8'hFF, 16, 66};
    vecs[3] = '{16'h00F0, 8'h80, 4, 54};
    vecs[4] = '{16'hAAAA, 8'h7F, 8, 58};

    reset = 1'b1; start = 1'b0; weCsd = 1'b0;
    address = 4'd0; dataIn = 8'h00; Zk = 1'bx; ZCsdK = 1'bx;
    repeat (2) tick();
    check_output("reset done", done, 0);
    check_output("reset Zcnt", Zcnt, 1);
    check_output("reset Zcsd", Zcsd, 1);
    check_output("reset Zi", Zi, 0);
    check_output("reset dataOut", dataOut, 0);
    check_output("reset dataOutK", dataOutK, 0);
    check_output("reset strobes", {Load, reCsd, enable, enCnt, loadCnt,
                                   reK, weK, kSel, selSaveK}, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < 16; a++)
        ref_mem[a] = vecs[v].mask[a] ? vecs[v].val : 8'h00;
      apply_stimulus();
      run_scan($sformatf("vec%0d", v), vecs[v].exp_lat, vecs[v].exp_cnt, -1);
    end

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++)
        ref_mem[a] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      apply_stimulus();
      run_scan($sformatf("rand%0d", r), 50 + model_count(), model_count(), -1);
    end

    for (int a = 0; a < 16; a++)
      ref_mem[a] = ($urandom_range(0, 2) == 0) ? 8'h21 : 8'h00;
    apply_stimulus();
    run_scan("lockout", 50 + model_count(), model_count(), 10);

    for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
    ref_mem[1] = 8'h03;
    ref_mem[5] = 8'hF0;
    apply_stimulus();
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (weK && sel_i == 4'd5) found = 1'b1;
    end
    check_output("abort reached SAVE5", found, 1);
    reset = 1'b1;
    tick();
    check_output("abort done", done, 0);
    check_output("abort Zcnt", Zcnt, 1);
    check_output("abort dataOut", dataOut, 0);
    check_output("abort sel_i", sel_i, 0);
    check_output("abort strobes", {Load, reCsd, enable, enCnt, loadCnt,
                                   reK, weK, kSel, selSaveK}, 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_output("abort idle done", done, 0);
    for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
    run_scan("post-abort", 50, 0, -1);
    start = 1'b1;
    for (int c = 0; c < 200 && !done; c++) tick();
    address = 4'd0;
    #1;
    check_output("post-abort K0 cleared", dataOutK, 0);
    start = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
